// File: rtl/led_chain_node.sv
// Daisy-chained one-wire LED pixel node: decodes a pulse-width NRZ stream, keeps the
// first CHANNELS*CH_WIDTH bits as its own pixel, forwards the rest, and drives PWM outputs.
`timescale 1ns/1ps

module led_chain_node #(
    parameter int unsigned CHANNELS     = 3,
    parameter int unsigned CH_WIDTH     = 8,
    parameter int unsigned T_MIN_HIGH   = 2,
    parameter int unsigned T_BIT_THRESH = 6,
    parameter int unsigned T_RESET      = 600
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_serial,
    output logic                o_serial,
    output logic [CHANNELS-1:0] o_pwm,
    output logic                o_frame_done
);

    localparam int unsigned NBITS      = CHANNELS * CH_WIDTH;
    localparam int unsigned BIT_CNT_W  = $clog2(NBITS + 1);
    localparam int unsigned TIME_CNT_W = $clog2(T_RESET + 1);

    typedef enum logic {
        CAPTURE = 1'b0,
        FORWARD = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic                   sync_meta;
    logic                   s_in;
    logic                   s_prev;

    logic [TIME_CNT_W-1:0]  hi_cnt;
    logic [TIME_CNT_W-1:0]  lo_cnt;

    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [BIT_CNT_W-1:0]   bit_cnt_next;
    logic [NBITS-1:0]       shadow;
    logic [NBITS-1:0]       shadow_next;

    logic [CH_WIDTH-1:0]    frame_ch [CHANNELS];
    logic [CH_WIDTH-1:0]    duty     [CHANNELS];
    logic [CH_WIDTH-1:0]    pwm_cnt;

    logic                   rise_c;
    logic                   fall_c;
    logic                   bit_valid_c;
    logic                   bit_val_c;
    logic                   latch_c;
    logic                   frame_full_c;
    logic                   load_duty_c;

    // Edge detection and pulse classification on the synchronised line
    assign rise_c       = s_in & ~s_prev;
    assign fall_c       = ~s_in & s_prev;
    assign bit_valid_c  = fall_c && (hi_cnt >= TIME_CNT_W'(T_MIN_HIGH));
    assign bit_val_c    = hi_cnt > TIME_CNT_W'(T_BIT_THRESH);
    // Latch fires on the cycle the low run becomes T_RESET long; a rising line never latches
    assign latch_c      = ~s_in && (lo_cnt == TIME_CNT_W'(T_RESET - 1));
    assign frame_full_c = bit_cnt == BIT_CNT_W'(NBITS);

    // Channel 0 arrives first, so it sits in the most significant slice of the shadow
    for (genvar c = 0; c < CHANNELS; c++) begin : g_slice
        assign frame_ch[c] = shadow[NBITS - 1 - c * CH_WIDTH -: CH_WIDTH];
    end

    // Input synchroniser and previous-sample register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_meta <= 1'b0;
            s_in      <= 1'b0;
            s_prev    <= 1'b0;
        end else begin
            sync_meta <= i_serial;
            s_in      <= sync_meta;
            s_prev    <= s_in;
        end
    end

    // High/low run-length counters; the rising-edge cycle is the first high clock
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hi_cnt <= '0;
            lo_cnt <= '0;
        end else begin
            if (rise_c) begin
                hi_cnt <= TIME_CNT_W'(1);
            end else if (s_in && (hi_cnt != TIME_CNT_W'(T_RESET))) begin
                hi_cnt <= hi_cnt + TIME_CNT_W'(1);
            end

            if (rise_c) begin
                lo_cnt <= '0;
            end else if (!s_in && (lo_cnt != TIME_CNT_W'(T_RESET))) begin
                lo_cnt <= lo_cnt + TIME_CNT_W'(1);
            end
        end
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= CAPTURE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, shift and latch decisions
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shadow_next  = shadow;
        load_duty_c  = 1'b0;

        case (state)
            CAPTURE: begin
                if (bit_valid_c) begin
                    shadow_next  = {shadow[NBITS-2:0], bit_val_c};
                    bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
                    if (bit_cnt == BIT_CNT_W'(NBITS - 1)) begin
                        state_next = FORWARD;
                    end
                end
            end
            FORWARD: begin
                state_next = FORWARD;
            end
            default: begin
                state_next = CAPTURE;
            end
        endcase

        // A latch ends the frame in either state; only a complete pixel reaches the duty registers
        if (latch_c) begin
            state_next   = CAPTURE;
            bit_cnt_next = '0;
            shadow_next  = '0;
            load_duty_c  = frame_full_c;
        end
    end

    // Bit counter and shadow register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bit_cnt <= '0;
            shadow  <= '0;
        end else begin
            bit_cnt <= bit_cnt_next;
            shadow  <= shadow_next;
        end
    end

    // Forwarded stream and frame-done pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_serial     <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_serial     <= (state == FORWARD) ? s_in : 1'b0;
            o_frame_done <= load_duty_c;
        end
    end

    // Duty registers, free-running PWM counter and PWM comparators
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pwm_cnt <= '0;
            o_pwm   <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                duty[c] <= '0;
            end
        end else begin
            pwm_cnt <= pwm_cnt + CH_WIDTH'(1);
            for (int c = 0; c < CHANNELS; c++) begin
                if (load_duty_c) begin
                    duty[c] <= frame_ch[c];
                end
                o_pwm[c] <= pwm_cnt < duty[c];
            end
        end
    end

endmodule

// File: tb/tb_led_chain_node.sv
// Directed/randomised bench for led_chain_node against a pulse-level pixel model.
`timescale 1ns/1ps

module tb_led_chain_node;

    localparam int unsigned CHANNELS     = 3;
    localparam int unsigned CH_WIDTH     = 8;
    localparam int unsigned T_MIN_HIGH   = 2;
    localparam int unsigned T_BIT_THRESH = 6;
    localparam int unsigned T_RESET      = 600;
    localparam int          NBITS        = 24;

    logic                clk = 1'b0;
    logic                rst;
    logic                ser_in;
    logic                ser_out;
    logic [CHANNELS-1:0] pwm;
    logic                frame_done;

    always #5 clk = ~clk;

    led_chain_node #(
        .CHANNELS     (CHANNELS),
        .CH_WIDTH     (CH_WIDTH),
        .T_MIN_HIGH   (T_MIN_HIGH),
        .T_BIT_THRESH (T_BIT_THRESH),
        .T_RESET      (T_RESET)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_serial     (ser_in),
        .o_serial     (ser_out),
        .o_pwm        (pwm),
        .o_frame_done (frame_done)
    );

    int          errors = 0;
    int          checks = 0;
    int          fd_seen = 0;
    int          exp_fd = 0;
    // [0] = input one step ago, [1] = two steps ago
    logic [1:0]  in_hist = '0;
    logic [1:0]  fwd_hist = '0;

    // Pixel model: bits received so far in this frame, their value, and latched duty
    int          m_cnt = 0;
    logic [23:0] m_val = '0;
    int          m_duty [CHANNELS] = '{0, 0, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive input, sample after the edge, check the forwarded stream
    task automatic step(input logic v, input logic fwd);
        ser_in = v;
        @(negedge clk);
        check("o_serial", 32'(ser_out), 32'(fwd_hist[1] ? in_hist[1] : 1'b0));
        if (frame_done === 1'b1) fd_seen++;
        in_hist  = {in_hist[0], v};
        fwd_hist = {fwd_hist[0], fwd};
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        in_hist  = '0;
        fwd_hist = '0;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
        check("rst_o_serial", 32'(ser_out), 32'd0);
        check("rst_o_pwm", 32'(pwm), 32'd0);
        check("rst_o_frame_done", 32'(frame_done), 32'd0);
        rst   = 1'b0;
        m_cnt = 0;
        m_val = '0;
        for (int c = 0; c < CHANNELS; c++) m_duty[c] = 0;
    endtask

    // One high pulse of h clocks followed by low clocks, with model update
    task automatic send_pulse(input int h, input int low);
        logic valid;
        logic fwd;
        valid = (h >= int'(T_MIN_HIGH));
        fwd   = valid && (m_cnt >= NBITS);
        for (int i = 0; i < h; i++) step(1'b1, fwd);
        for (int i = 0; i < low; i++) step(1'b0, fwd);
        if (valid && m_cnt < NBITS) begin
            if (h > int'(T_BIT_THRESH)) m_val[NBITS-1-m_cnt] = 1'b1;
            m_cnt++;
        end
        if (low >= int'(T_RESET)) begin
            if (m_cnt >= NBITS) begin
                for (int c = 0; c < CHANNELS; c++)
                    m_duty[c] = int'((m_val >> (8 * (CHANNELS - 1 - c))) & 24'hFF);
                exp_fd++;
            end
            m_cnt = 0;
            m_val = '0;
        end
    endtask

    // Send the low n bits of val MSB-first; last_low < 0 keeps the normal bit period
    task automatic send_bits(input logic [23:0] val, input int n, input int last_low,
                             input logic rnd, input logic glitch);
        logic b;
        int   h;
        int   low;
        for (int i = 0; i < n; i++) begin
            b   = val[n-1-i];
            h   = rnd ? (b ? int'($urandom_range(7, 12)) : int'($urandom_range(2, 6)))
                      : (b ? 9 : 4);
            low = rnd ? int'($urandom_range(3, 8)) : 15 - h;
            if (i == n - 1 && last_low >= 0) low = last_low;
            if (glitch && (i % 3 == 1) && (i != n - 1)) begin
                send_pulse(h, 3);
                send_pulse(1, 4);
            end else begin
                send_pulse(h, low);
            end
        end
    endtask

    // Count PWM high cycles over one full PWM period and check latch count
    task automatic measure(input string tag);
        int hi [CHANNELS];
        for (int c = 0; c < CHANNELS; c++) hi[c] = 0;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 1'b0);
            for (int c = 0; c < CHANNELS; c++) if (pwm[c] === 1'b1) hi[c]++;
        end
        for (int c = 0; c < CHANNELS; c++)
            check($sformatf("%s_pwm%0d_high", tag, c), 32'(hi[c]), 32'(m_duty[c]));
        check({tag, "_frame_done_count"}, 32'(fd_seen), 32'(exp_fd));
    endtask

    initial begin
        logic [23:0] v;
        rst    = 1'b1;
        ser_in = 1'b0;

        do_reset(4);
        measure("after_reset");

        // Known frame with nominal timing
        send_bits(24'hFF8000, 24, 700, 1'b0, 1'b0);
        measure("ff8000");
        check("ff8000_pwm0_abs", 32'(m_duty[0]), 32'd255);

        // Two pixels: this node keeps the first, forwards the second
        send_bits(24'h123456, 24, -1, 1'b0, 1'b0);
        send_bits(24'hABCDEF, 24, 700, 1'b0, 1'b0);
        measure("chain48");

        // Partial frame is discarded, next frame decodes from bit 0
        v = 24'($urandom);
        send_bits(v, 10, 700, 1'b1, 1'b0);
        measure("partial10");
        v = 24'($urandom);
        send_bits(v, 24, 700, 1'b1, 1'b0);
        measure("after_partial");

        // Glitches between bits, ending on a gap of exactly T_RESET
        v = 24'($urandom);
        send_bits(v, 24, int'(T_RESET), 1'b1, 1'b1);
        measure("glitch");

        // Low for one clock short of T_RESET mid-frame: no latch
        v = 24'($urandom);
        send_bits(24'(v >> 12), 12, int'(T_RESET) - 1, 1'b1, 1'b0);
        send_bits(v, 12, 700, 1'b1, 1'b0);
        measure("gap599");

        // One-clock reset mid-frame, then a normal frame
        v = 24'($urandom);
        send_bits(v, 12, -1, 1'b1, 1'b0);
        do_reset(1);
        v = 24'($urandom);
        send_bits(v, 24, 700, 1'b1, 1'b0);
        measure("after_midreset");

        // Random frames with a random number of forwarded bits
        for (int k = 0; k < 3; k++) begin
            v = 24'($urandom);
            send_bits(v, 24, -1, 1'b1, 1'b0);
            v = 24'($urandom);
            send_bits(v, int'($urandom_range(1, 24)), 700, 1'b1, 1'b0);
            measure($sformatf("random%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
